// File: rtl/encoder_filter.sv
// ----------------------------------------------------------------------------
// encoder_filter
//   Conditions raw quadrature phases from the linear encoder before they reach
//   the encoder_in counter. Each phase is synchronised through two flops, and a
//   new level is accepted only after it has been stable for FILT_LEN cycles.
//   A level that goes away before then is counted as a glitch. When both
//   phases are committed on the same edge, that is an illegal quadrature step.
//   It is still committed, but it pulses err_strobe and is counted. A sticky
//   fault is raised once the error count reaches ERR_LIMIT.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   phaseA       raw encoder phase A (asynchronous to clk)
//   phaseB       raw encoder phase B (asynchronous to clk)
//   err_clr      synchronous clear of glitch_count, err_count and fault
//   phaseA_f     filtered phase A
//   phaseB_f     filtered phase B
//   err_strobe   one-cycle pulse after an illegal (both-phase) commit
//   glitch_count saturating count of rejected pulses on either phase
//   err_count    saturating count of illegal transitions
//   fault        sticky, set once err_count >= ERR_LIMIT
// ----------------------------------------------------------------------------
module encoder_filter #(
    parameter int unsigned FILT_LEN  = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ERR_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phaseA,
    input  logic             phaseB,
    input  logic             err_clr,
    output logic             phaseA_f,
    output logic             phaseB_f,
    output logic             err_strobe,
    output logic [CNT_W-1:0] glitch_count,
    output logic [CNT_W-1:0] err_count,
    output logic             fault
);

    localparam logic [1:0] StFill = 2'd0;
    localparam logic [1:0] StInit = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;

    localparam logic [7:0]       LastCnt = 8'(FILT_LEN - 1);
    localparam int unsigned      SumW    = CNT_W + 2;
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    // Wide enough for both the counter and the integer limit.
    localparam int unsigned      CmpW    = (CNT_W > 32) ? CNT_W : 32;

    logic [1:0]       state_q, state_d;
    logic             fill_q, fill_d;
    // Bit 0 is phase A, bit 1 is phase B.
    logic [1:0]       s1_q, s2_q;
    logic [1:0]       f_q, f_d;
    logic [1:0][7:0]  cnt_q, cnt_d;
    logic             strobe_q, strobe_d;
    logic [CNT_W-1:0] glitch_q, glitch_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             fault_q, fault_d;

    logic [1:0]       commit;
    logic [1:0]       glitch;
    logic             illegal;
    logic [SumW-1:0]  glitch_sum;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        commit  = 2'b00;
        glitch  = 2'b00;
        case (state_q)
            StFill: begin
                // Two edges let s1/s2 fill before their value is trusted.
                fill_d = 1'b1;
                if (fill_q) begin
                    state_d = StInit;
                end
            end
            StInit: begin
                // Adopt whatever level is present without error or glitch checks.
                f_d     = s2_q;
                state_d = StRun;
            end
            StRun: begin
                for (int i = 0; i < 2; i++) begin
                    if (s2_q[i] != f_q[i]) begin
                        if (cnt_q[i] == LastCnt) begin
                            f_d[i]    = s2_q[i];
                            cnt_d[i]  = 8'd0;
                            commit[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end else if (cnt_q[i] != 8'd0) begin
                        cnt_d[i]  = 8'd0;
                        glitch[i] = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StFill;
                fill_d  = 1'b0;
            end
        endcase

        illegal  = &commit;
        strobe_d = illegal;

        // Both channels can glitch together, so the step can be 2.
        glitch_sum = SumW'(glitch_q) + SumW'(glitch[0]) + SumW'(glitch[1]);
        if (glitch_sum > SumW'(CntMax)) begin
            glitch_d = CntMax;
        end else begin
            glitch_d = glitch_sum[CNT_W-1:0];
        end

        err_d = err_q;
        if (illegal && (err_q != CntMax)) begin
            err_d = err_q + 1'b1;
        end

        fault_d = fault_q | (CmpW'(err_d) >= CmpW'(ERR_LIMIT));

        // Clearing wins over any coincident glitch or error.
        if (err_clr) begin
            glitch_d = '0;
            err_d    = '0;
            fault_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StFill;
            fill_q   <= 1'b0;
            s1_q     <= 2'b00;
            s2_q     <= 2'b00;
            f_q      <= 2'b00;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            glitch_q <= '0;
            err_q    <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            s1_q     <= {phaseB, phaseA};
            s2_q     <= s1_q;
            f_q      <= f_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            glitch_q <= glitch_d;
            err_q    <= err_d;
            fault_q  <= fault_d;
        end
    end

    assign phaseA_f     = f_q[0];
    assign phaseB_f     = f_q[1];
    assign err_strobe   = strobe_q;
    assign glitch_count = glitch_q;
    assign err_count    = err_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_encoder_filter.sv
// ----------------------------------------------------------------------------
// tb_encoder_filter
//   Directed bench for encoder_filter. The main instance uses the default
//   parameters. A second instance with CNT_W=2 shares the same stimulus, so
//   that counter saturation can be observed on it.
// ----------------------------------------------------------------------------
module tb_encoder_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        phaseA = 1'b0;
    logic        phaseB = 1'b0;
    logic        err_clr = 1'b0;

    logic        fa, fb, strobe, fault;
    logic [15:0] glitch_cnt, err_cnt;

    logic        s_fa, s_fb, s_strobe, s_fault;
    logic [1:0]  s_glitch, s_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    encoder_filter #(
        .FILT_LEN (4),
        .CNT_W    (16),
        .ERR_LIMIT(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .phaseA      (phaseA),
        .phaseB      (phaseB),
        .err_clr     (err_clr),
        .phaseA_f    (fa),
        .phaseB_f    (fb),
        .err_strobe  (strobe),
        .glitch_count(glitch_cnt),
        .err_count   (err_cnt),
        .fault       (fault)
    );

    encoder_filter #(
        .FILT_LEN (4),
        .CNT_W    (2),
        .ERR_LIMIT(3)
    ) dut_s (
        .clk         (clk),
        .rst         (rst),
        .phaseA      (phaseA),
        .phaseB      (phaseB),
        .err_clr     (err_clr),
        .phaseA_f    (s_fa),
        .phaseB_f    (s_fb),
        .err_strobe  (s_strobe),
        .glitch_count(s_glitch),
        .err_count   (s_err),
        .fault       (s_fault)
    );

    // Advance one rising edge; outputs are sampled 1 time unit after it.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic a, input logic b);
        rst     = 1'b1;
        err_clr = 1'b0;
        phaseA  = a;
        phaseB  = b;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(1'b1, 1'b1);
        n_tests++;
        if ({fa, fb, strobe, fault, glitch_cnt, err_cnt} !== 36'd0) begin
            $display("FAIL reset_outputs: got %h, expected 0",
                     {fa, fb, strobe, fault, glitch_cnt, err_cnt});
            n_fail++;
        end
        n_tests++;
        if ({s_fa, s_fb, s_strobe, s_fault, s_glitch, s_err} !== 8'd0) begin
            $display("FAIL reset_outputs_small: got %h, expected 0",
                     {s_fa, s_fb, s_strobe, s_fault, s_glitch, s_err});
            n_fail++;
        end
        tick(2);
        n_tests++;
        if ({fa, fb} !== 2'b00) begin
            $display("FAIL fill_hold: got %b, expected 00", {fa, fb});
            n_fail++;
        end
        tick(1);
        n_tests++;
        if ({fa, fb} !== 2'b11) begin
            $display("FAIL init_load: got %b, expected 11", {fa, fb});
            n_fail++;
        end
        n_tests++;
        if ({strobe, err_cnt, glitch_cnt} !== 33'd0) begin
            $display("FAIL init_no_err: got strobe=%0d err=%0d glitch=%0d, expected 0 0 0",
                     strobe, err_cnt, glitch_cnt);
            n_fail++;
        end
    endtask

    task automatic test_accept;
        do_reset(1'b0, 1'b0);
        tick(3);
        phaseA = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            n_tests++;
            if (fa !== 1'b0) begin
                $display("FAIL accept_early edge %0d: got %0d, expected 0", k, fa);
                n_fail++;
            end
        end
        tick(1);
        n_tests++;
        if ({fa, fb, strobe} !== 3'b100) begin
            $display("FAIL accept_edge: got fa,fb,strobe=%b, expected 100", {fa, fb, strobe});
            n_fail++;
        end
        tick(1);
        n_tests++;
        if (strobe !== 1'b0) begin
            $display("FAIL accept_no_strobe: got %0d, expected 0", strobe);
            n_fail++;
        end
    endtask

    task automatic test_glitch;
        do_reset(1'b0, 1'b0);
        tick(3);
        phaseA = 1'b1;
        tick(3);
        phaseA = 1'b0;
        tick(6);
        n_tests++;
        if (fa !== 1'b0 || glitch_cnt !== 16'd1) begin
            $display("FAIL glitch_reject: got fa=%0d glitch=%0d, expected 0 1", fa, glitch_cnt);
            n_fail++;
        end
        phaseA = 1'b1;
        tick(4);
        phaseA = 1'b0;
        tick(2);
        n_tests++;
        if (fa !== 1'b1) begin
            $display("FAIL pulse4_accept: got %0d, expected 1", fa);
            n_fail++;
        end
        tick(8);
        n_tests++;
        if (fa !== 1'b0 || glitch_cnt !== 16'd1) begin
            $display("FAIL pulse4_return: got fa=%0d glitch=%0d, expected 0 1", fa, glitch_cnt);
            n_fail++;
        end
    endtask

    task automatic test_illegal;
        for (int i = 0; i < 8; i++) begin
            logic v;
            v = (i % 2 == 0);
            phaseA = v;
            phaseB = v;
            tick(5);
            n_tests++;
            if ({fa, fb} !== {2{~v}}) begin
                $display("FAIL illegal_early %0d: got %b, expected %b", i, {fa, fb}, {2{~v}});
                n_fail++;
            end
            tick(1);
            n_tests++;
            if ({fa, fb} !== {2{v}} || strobe !== 1'b1) begin
                $display("FAIL illegal_commit %0d: got f=%b strobe=%0d, expected %b 1",
                         i, {fa, fb}, strobe, {2{v}});
                n_fail++;
            end
            n_tests++;
            if (err_cnt !== 16'(i + 1) || fault !== (i + 1 >= 8)) begin
                $display("FAIL illegal_count %0d: got err=%0d fault=%0d, expected %0d %0d",
                         i, err_cnt, fault, i + 1, (i + 1 >= 8));
                n_fail++;
            end
            tick(1);
            n_tests++;
            if (strobe !== 1'b0) begin
                $display("FAIL illegal_strobe_len %0d: got %0d, expected 0", i, strobe);
                n_fail++;
            end
        end
    endtask

    task automatic test_clr;
        phaseA = 1'b1;
        phaseB = 1'b1;
        tick(5);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        n_tests++;
        if (err_cnt !== 16'd0 || fault !== 1'b0 || strobe !== 1'b1 || {fa, fb} !== 2'b11) begin
            $display("FAIL clr_priority: got err=%0d fault=%0d strobe=%0d f=%b, expected 0 0 1 11",
                     err_cnt, fault, strobe, {fa, fb});
            n_fail++;
        end
        n_tests++;
        if (glitch_cnt !== 16'd0 || s_glitch !== 2'd0) begin
            $display("FAIL clr_glitch: got %0d/%0d, expected 0/0", glitch_cnt, s_glitch);
            n_fail++;
        end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 3; i++) begin
            phaseA = 1'b0;
            tick(2);
            phaseA = 1'b1;
            tick(6);
            n_tests++;
            if (glitch_cnt !== 16'(i + 1) || s_glitch !== 2'(i + 1)) begin
                $display("FAIL glitch_step %0d: got %0d/%0d, expected %0d/%0d",
                         i, glitch_cnt, s_glitch, i + 1, i + 1);
                n_fail++;
            end
        end
        // Both phases glitch on the same edge.
        phaseA = 1'b0;
        phaseB = 1'b0;
        tick(2);
        phaseA = 1'b1;
        phaseB = 1'b1;
        tick(6);
        n_tests++;
        if (glitch_cnt !== 16'd5 || s_glitch !== 2'd3) begin
            $display("FAIL glitch_dual_sat: got %0d/%0d, expected 5/3", glitch_cnt, s_glitch);
            n_fail++;
        end
        n_tests++;
        if ({fa, fb} !== 2'b11 || err_cnt !== 16'd0) begin
            $display("FAIL glitch_dual_hold: got f=%b err=%0d, expected 11 0", {fa, fb}, err_cnt);
            n_fail++;
        end
    endtask

    task automatic test_rst_mid;
        phaseA = 1'b0;
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({fa, fb, strobe, fault, glitch_cnt, err_cnt} !== 36'd0) begin
            $display("FAIL rst_mid_async: got %h, expected 0",
                     {fa, fb, strobe, fault, glitch_cnt, err_cnt});
            n_fail++;
        end
        phaseA = 1'b1;
        phaseB = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        n_tests++;
        if ({fa, fb} !== 2'b00) begin
            $display("FAIL rst_mid_fill: got %b, expected 00", {fa, fb});
            n_fail++;
        end
        tick(1);
        n_tests++;
        if ({fa, fb} !== 2'b11 || {strobe, err_cnt, glitch_cnt} !== 33'd0) begin
            $display("FAIL rst_mid_init: got f=%b strobe=%0d err=%0d glitch=%0d, expected 11 0 0 0",
                     {fa, fb}, strobe, err_cnt, glitch_cnt);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_glitch();
        test_illegal();
        test_clr();
        test_saturate();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
